lcd_reader: RTL

// - Read-cycle controller for the HD44780-style 8-bit text LCD; the read counterpart of the LCD write controller.
// - Reads the busy flag and address counter (RS=0) or a DDRAM/CGRAM byte (RS=1) and returns the byte to the host.
// - Sits beside the write controller under the LCD top level; the top level muxes LCD_RS/LCD_RW/LCD_E and tristates LCD_data from `active`.

---
 rtl/lcd_pkg.sv | 30 +++
 rtl/lcd_reader.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: state encoding and default HD44780 bus timing shared by the LCD
// read and write controllers. Optional feature macro: LCD_POLL_EN.
package lcd_pkg;

    // FSM state encoding (plain constants so older tools can consume them)
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_EPULSE = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam logic [2:0] ST_GAP    = 3'd5;

    // Default timing in 50 MHz clock cycles
    localparam int LCD_PW_SU    = 3;     // RS/RW setup before E rises (>40ns)
    localparam int LCD_PW_E     = 12;    // E high time (>230ns)
    localparam int LCD_PW_H     = 1;     // RS/RW hold after E falls (>10ns)
    localparam int LCD_POLL_GAP = 50;    // idle cycles between busy polls
    localparam int LCD_POLL_MAX = 4096;  // busy polls before giving up

    // Width of a down-counter able to hold the largest of the four delays
    function automatic int lcd_cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/lcd_reader.sv
// lcd_reader: read-cycle controller for an HD44780-style 8-bit LCD.
// Reads BF/address (RS=0) or a RAM byte (RS=1) and returns it to the host.
// Optional feature macro: LCD_POLL_EN (RS=0 starts become a busy-wait loop).
module lcd_reader
    import lcd_pkg::*;
#(
    parameter int PW_SU    = LCD_PW_SU,
    parameter int PW_E     = LCD_PW_E,
    parameter int PW_H     = LCD_PW_H,
    parameter int POLL_GAP = LCD_POLL_GAP
`ifdef LCD_POLL_EN
    ,
    parameter int POLL_MAX = LCD_POLL_MAX
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       RS,
    output logic [7:0] rd_data,
    output logic       busy_flag,
    output logic       done,
    output logic       active,
    output logic       timeout,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_E,
    input  logic [7:0] LCD_data_in
);

    localparam int CNT_W = lcd_cnt_width(PW_SU, PW_E, PW_H, POLL_GAP);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rs_q;
    logic [7:0]       r_rd_data;
    logic             r_busy_flag;
    logic             r_done;
    logic             r_active;
    logic             r_lcd_e;
    logic             r_timeout;

    logic             w_cnt_zero;
    logic             w_poll_again;
    logic             w_poll_expire;

    assign w_cnt_zero = (r_cnt == '0);

`ifdef LCD_POLL_EN
    localparam int POLL_W = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;

    logic [POLL_W-1:0] r_poll_cnt;
    logic              w_poll_busy;
    logic              w_poll_last;

    // A busy-wait only applies to BF reads that came back busy
    assign w_poll_busy   = (r_state == ST_DONE) && !r_rs_q && r_busy_flag;
    assign w_poll_last   = (r_poll_cnt == POLL_W'(POLL_MAX - 1));
    assign w_poll_again  = w_poll_busy && !w_poll_last;
    assign w_poll_expire = w_poll_busy && w_poll_last;
`else
    assign w_poll_again  = 1'b0;
    assign w_poll_expire = 1'b0;
`endif

    // Main FSM with a shared down-counter; counter only decrements when nonzero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_rs_q      <= 1'b0;
            r_rd_data   <= 8'h00;
            r_busy_flag <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
`ifdef LCD_POLL_EN
            r_poll_cnt  <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_rs_q    <= RS;
                        r_cnt     <= CNT_W'(PW_SU - 1);
                        r_state   <= ST_SETUP;
                        r_timeout <= 1'b0;
`ifdef LCD_POLL_EN
                        r_poll_cnt <= '0;
`endif
                    end
                end
                ST_SETUP: begin
                    if (w_cnt_zero) begin
                        r_cnt   <= CNT_W'(PW_E - 1);
                        r_state <= ST_EPULSE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_EPULSE: begin
                    if (w_cnt_zero) begin
                        // Sample at the end of the E pulse, when data has long settled
                        r_rd_data <= LCD_data_in;
                        if (!r_rs_q) begin
                            r_busy_flag <= LCD_data_in[7];
                        end
                        r_cnt   <= CNT_W'(PW_H - 1);
                        r_state <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (w_cnt_zero) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (w_poll_again) begin
`ifdef LCD_POLL_EN
                        r_poll_cnt <= r_poll_cnt + 1'b1;
`endif
                        r_cnt   <= CNT_W'(POLL_GAP - 1);
                        r_state <= ST_GAP;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                        if (w_poll_expire) begin
                            r_timeout <= 1'b1;
                        end
                    end
                end
`ifdef LCD_POLL_EN
                ST_GAP: begin
                    if (w_cnt_zero) begin
                        r_cnt   <= CNT_W'(PW_SU - 1);
                        r_state <= ST_SETUP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus strobes registered from the state so the pins are glitch-free
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_active <= 1'b0;
            r_lcd_e  <= 1'b0;
        end else begin
            r_active <= (r_state == ST_SETUP) || (r_state == ST_EPULSE) || (r_state == ST_HOLD);
            r_lcd_e  <= (r_state == ST_EPULSE);
        end
    end

    assign rd_data   = r_rd_data;
    assign busy_flag = r_busy_flag;
    assign done      = r_done;
    assign active    = r_active;
    assign timeout   = r_timeout;
    assign LCD_RS    = r_rs_q;
    assign LCD_RW    = r_active;
    assign LCD_E     = r_lcd_e;

endmodule
